// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared types and helpers for the dual-ADC capture block.
//   - state_t      : capture FSM states
//   - DEF_*        : default parameter values for adc_capture
//   - ob_to_tc()   : offset-binary to two's-complement conversion
package adc_capture_pkg;

  localparam int DEF_DATA_W     = 12;
  localparam int DEF_CLK_DIV    = 2;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Offset binary -> two's complement is a flip of the sample MSB.
  // Works on a 32-bit container; the caller truncates to its own width.
  function automatic logic [31:0] ob_to_tc(input logic [31:0] raw, input int unsigned width);
    return raw ^ (32'd1 << (width - 1));
  endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n   : clock, async active-low reset (pointers only)
//   push, din    : write strobe/data (taken when not full, or full with a pop)
//   pop          : read strobe (ignored when empty)
//   dout         : head word, forced to 0 while empty
//   full, empty  : occupancy flags
module adc_sample_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign empty = (wr_ptr == rd_ptr);
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Stale storage is never visible: the head reads as 0 whenever empty.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/adc_capture.sv
// adc_capture: drives two ADC sample clocks, captures both offset-binary
// buses mid-period, converts to two's complement and streams sample pairs
// through a FWFT FIFO.
//   sys_clk, rst_n        : system clock, async active-low reset (sync release)
//   start, stop           : one-cycle capture begin / abort pulses
//   burst_len             : pairs per burst, 0 = continuous
//   ad1_clk, ad2_clk      : ADC sample clocks (sys_clk / (2*CLK_DIV))
//   ad1_data, ad2_data    : ADC output buses (offset binary)
//   m_valid/m_ready       : sample stream handshake
//   m_data1, m_data2      : sample pair, two's complement
//   busy                  : capture in progress
//   overflow, clr_ovf     : sticky drop flag and its clear
module adc_capture import adc_capture_pkg::*; #(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [15:0]       burst_len,
  output logic              ad1_clk,
  output logic              ad2_clk,
  input  logic [DATA_W-1:0] ad1_data,
  input  logic [DATA_W-1:0] ad2_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data1,
  output logic [DATA_W-1:0] m_data2,
  output logic              busy,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Reset: asserts asynchronously, releases two sys_clk edges later.
  logic [1:0] rst_pipe;
  logic       rst_i;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_i = rst_pipe[1];

  // ADC clock divider; both ADC clocks share one register.
  logic [DIV_W-1:0] div_cnt;
  logic             ad_clk, div_wrap, sample_stb;

  assign div_wrap = (div_cnt == DIV_W'(CLK_DIV - 1));
  // Sample on the high->low transition: mid-period of the ADC output window.
  assign sample_stb = div_wrap && ad_clk;

  always_ff @(posedge sys_clk or negedge rst_i) begin
    if (!rst_i) begin
      div_cnt <= '0;
      ad_clk  <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      ad_clk  <= ~ad_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end
  assign ad1_clk = ad_clk;
  assign ad2_clk = ad_clk;

  // Two-stage input registers on both buses.
  logic [DATA_W-1:0] d1_q1, d1_q2, d2_q1, d2_q2;
  logic [DATA_W-1:0] conv1, conv2;

  always_ff @(posedge sys_clk or negedge rst_i) begin
    if (!rst_i) begin
      d1_q1 <= '0; d1_q2 <= '0;
      d2_q1 <= '0; d2_q2 <= '0;
    end else begin
      d1_q1 <= ad1_data; d1_q2 <= d1_q1;
      d2_q1 <= ad2_data; d2_q2 <= d2_q1;
    end
  end
  assign conv1 = DATA_W'(ob_to_tc(32'(d1_q2), DATA_W));
  assign conv2 = DATA_W'(ob_to_tc(32'(d2_q2), DATA_W));

  // Capture FSM.
  state_t      state, state_nxt;
  logic [15:0] len_q, cnt_q;
  logic        busy_i, load, cap, accept, drop, done;
  logic        fifo_full, fifo_empty, pop;

  always_ff @(posedge sys_clk or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (stop || done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // stop masks a coincident strobe; a full FIFO is still writable when a pop
  // frees a slot in the same cycle. Drops still advance the pair count.
  always_comb begin
    busy_i = (state == ST_RUN);
    load   = (state == ST_IDLE) && start;
    cap    = busy_i && sample_stb && !stop;
    accept = cap && (!fifo_full || pop);
    drop   = cap && fifo_full && !pop;
    done   = cap && (len_q != 16'd0) && (cnt_q + 16'd1 == len_q);
  end
  assign busy = busy_i;

  always_ff @(posedge sys_clk or negedge rst_i) begin
    if (!rst_i) begin
      len_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      len_q <= burst_len;
      cnt_q <= '0;
    end else if (cap) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // The accepted pair is written one cycle after its strobe; strobes are at
  // least two cycles apart, so the slot reserved at the strobe is still free.
  logic                pend;
  logic [2*DATA_W-1:0] pend_data, fifo_dout;

  always_ff @(posedge sys_clk or negedge rst_i) begin
    if (!rst_i) begin
      pend      <= 1'b0;
      pend_data <= '0;
    end else begin
      pend <= accept;
      if (accept) pend_data <= {conv1, conv2};
    end
  end

  always_ff @(posedge sys_clk or negedge rst_i) begin
    if (!rst_i)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;

  adc_sample_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (rst_i),
    .push  (pend),
    .din   (pend_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_data1 = fifo_dout[2*DATA_W-1:DATA_W];
  assign m_data2 = fifo_dout[DATA_W-1:0];

endmodule

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 12, the ADC sample width per channel.
REQ-002 SHALL have parameter CLK_DIV, default 2, the sys_clk cycles per ADC clock half-period (legal: 1 or more).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, the sample-pair FIFO depth (power of 2, 4 or more).
REQ-004 SHALL have ports `sys_clk` in 1 (single clock) and `rst_n` in 1 (asynchronous, active-low reset).
REQ-005 SHALL have port `start` in 1: one-cycle pulse that begins capture.
REQ-006 SHALL have port `stop` in 1: one-cycle pulse that aborts capture.
REQ-007 SHALL have port `burst_len` in 16: number of sample pairs to capture; 0 means continuous.
REQ-008 SHALL have ports `ad1_clk` and `ad2_clk`, out 1 each: ADC sample clocks.
REQ-009 SHALL have ports `ad1_data` and `ad2_data`, in DATA_W each: ADC offset-binary output buses.
REQ-010 SHALL have ports `m_valid` out 1, `m_ready` in 1, `m_data1` out DATA_W and `m_data2` out DATA_W: the sample stream, in two's complement.
REQ-011 SHALL have ports `busy` out 1 (FSM in RUN), `overflow` out 1 (sticky) and `clr_ovf` in 1.

Function
REQ-012 SHALL use a divider counter that runs 0..CLK_DIV-1 and, on wrap, toggles `ad1_clk` and `ad2_clk` together, so both are sys_clk/(2*CLK_DIV) with 50% duty.
REQ-013 SHALL assert internal `sample_stb` for exactly one cycle, on the cycle the ADC clocks are driven from high to low, i.e. mid-period.
REQ-014 SHALL register `adN_data` through two sys_clk stages every cycle and latch the stage-2 value only when `sample_stb` is high.
REQ-015 SHALL convert offset binary to two's complement by inverting the MSB only; 0x000 becomes -2048, 0x800 becomes 0 and 0xFFF becomes +2047 when DATA_W is 12.
REQ-016 SHALL implement an FSM with states IDLE and RUN:
- IDLE: `busy` is 0. On `start`, latch `burst_len`, clear the pair count and go to RUN.
- RUN: on each `sample_stb`, push the converted pair and increment the count. When the latched length is non-zero and the count reaches it, go to IDLE.
- RUN: on `stop`, go to IDLE the next cycle.
REQ-017 SHALL ignore `start` while in RUN.
REQ-018 SHALL give `stop` priority over a `sample_stb` in the same cycle; that sample SHALL NOT be pushed.
REQ-019 SHALL never push samples while in IDLE; the FIFO still drains normally.
REQ-020 SHALL, when the FIFO is full at `sample_stb` and there is no pop that cycle:
- drop the pair;
- set `overflow`;
- still increment the count.
REQ-021 SHALL accept a push when full if a pop (`m_valid` && `m_ready`) occurs in the same cycle.
REQ-022 SHALL let a set event win over `clr_ovf` when both occur in the same cycle.
REQ-023 SHALL drive `m_valid` as FIFO-not-empty.
REQ-024 SHALL hold `m_data1`/`m_data2` stable while `m_valid` is high and `m_ready` is low.
REQ-025 SHALL make a pushed pair visible on `m_data1`/`m_data2` with `m_valid` high 2 cycles after its `sample_stb` when the FIFO is empty.
REQ-026 SHALL keep the ADC clocks running continuously in both states.

Reset
REQ-027 SHALL, on asynchronous `rst_n` low:
- set the FSM to IDLE and the divider to 0;
- drive `ad1_clk` and `ad2_clk` low;
- empty the FIFO;
- drive `m_valid`, `busy`, `overflow`, `m_data1` and `m_data2` to 0;
- clear the input stages and the count.
REQ-028 SHALL release reset synchronously to `sys_clk` (deassertion synchronizer inside or upstream).
REQ-029 SHALL discard any in-flight capture and FIFO contents on reset mid-operation.

Structure
REQ-030 SHALL place in `adc_capture_pkg`: the FSM state enum, the default DATA_W/CLK_DIV/FIFO_DEPTH constants, and the offset-binary-to-two's-complement function.
REQ-031 SHALL instantiate one sub-module, `adc_sample_fifo`: a synchronous FIFO of 2*DATA_W words with full/empty flags and first-word-fall-through output.

Verification
REQ-032 SHALL cover format: ad1 stepped 0x000/0x800/0xFFF, ad2 = 0x7FF, burst_len = 3 -> m_data1 = -2048/0/+2047, m_data2 = -1, then `busy` falls.
REQ-033 SHALL cover the burst: burst_len = 5 with `m_ready` held high -> exactly 5 pairs, `busy` low after the 5th `sample_stb`, no further pushes.
REQ-034 SHALL cover overflow: continuous mode, `m_ready` = 0, FIFO_DEPTH = 8 -> 8 pairs retained, 9th dropped, `overflow` = 1; `clr_ovf` pulse -> 0 unless a drop occurs in the same cycle.
REQ-035 SHALL cover stop: `stop` coincident with `sample_stb` -> that pair absent, FSM IDLE the next cycle, FIFO drains remaining pairs.
REQ-036 SHALL cover clocking: CLK_DIV = 3 -> ad clocks have a 6-cycle period, and `sample_stb` occurs only on the falling-transition cycle.
REQ-037 SHALL cover reset: `rst_n` pulsed low mid-burst with a non-empty FIFO -> all outputs 0 and ad clocks low immediately; after release, `start` begins a fresh burst with count 0.
